morse_tx_fifo: RTL and testbench

- Parametrised successor to the single-character Morse transmitter.
- Accepts 7-bit ASCII characters into an internal FIFO and transmits them back-to-back as keyed Morse on Y.
- Unit duration is set by a clock-cycle parameter. Covers A–Z, a–z (folded to upper case), 0–9 and space (word gap).
- Sits between the UART/character source and the key/LED output driver.

---
 rtl/morse_tx_fifo_if.sv | 23 ++
 rtl/morse_tx_fifo.sv | 230 +++++++++++++++++++++++
 tb/tb_morse_tx_fifo.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/morse_tx_fifo_if.sv
// Character-in / keyed-Morse-out bus for morse_tx_fifo.
// The character source is the master; the transmitter is the slave.
interface morse_tx_fifo_if;
  logic [6:0] RxData;
  logic       Wr;
  logic       Start;
  logic       Full;
  logic       Empty;
  logic       Busy;
  logic       Err;
  logic       Done;
  logic       Y;

  modport master (
    output RxData, Wr, Start,
    input  Full, Empty, Busy, Err, Done, Y
  );

  modport slave (
    input  RxData, Wr, Start,
    output Full, Empty, Busy, Err, Done, Y
  );
endinterface

// File: rtl/morse_tx_fifo.sv
// Queued Morse transmitter: ASCII characters enter a FIFO and are keyed out
// back-to-back on Y, with unit length set by UNIT_CYCLES.
module morse_tx_fifo #(
  parameter int UNIT_CYCLES = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic           CLK,
  input  logic           RST,
  morse_tx_fifo_if.slave bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(4 * UNIT_CYCLES + 1);

  localparam logic [TW-1:0] T_DOT  = TW'(UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_DASH = TW'(3 * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_CH   = TW'(3 * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_WD   = TW'(4 * UNIT_CYCLES - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, MARK, ELGAP, CHGAP, WDGAP, FIN} state_t;

  typedef struct packed {
    logic       ok;
    logic       space;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  // Pattern is left-aligned: bit 4 is the first element, 1 = dash.
  // Letters 65..90 (lower case folded), digits 48..57, space 32.
  function automatic code_t morse_rom(input logic [6:0] ch);
    logic [6:0] c;
    logic [7:0] lp;
    code_t      r;
    c  = (ch >= 7'd97 && ch <= 7'd122) ? ch - 7'd32 : ch;
    lp = 8'h00;
    case (c)
      7'd65: lp = {3'd2, 5'b01000};
      7'd66: lp = {3'd4, 5'b10000};
      7'd67: lp = {3'd4, 5'b10100};
      7'd68: lp = {3'd3, 5'b10000};
      7'd69: lp = {3'd1, 5'b00000};
      7'd70: lp = {3'd4, 5'b00100};
      7'd71: lp = {3'd3, 5'b11000};
      7'd72: lp = {3'd4, 5'b00000};
      7'd73: lp = {3'd2, 5'b00000};
      7'd74: lp = {3'd4, 5'b01110};
      7'd75: lp = {3'd3, 5'b10100};
      7'd76: lp = {3'd4, 5'b01000};
      7'd77: lp = {3'd2, 5'b11000};
      7'd78: lp = {3'd2, 5'b10000};
      7'd79: lp = {3'd3, 5'b11100};
      7'd80: lp = {3'd4, 5'b01100};
      7'd81: lp = {3'd4, 5'b11010};
      7'd82: lp = {3'd3, 5'b01000};
      7'd83: lp = {3'd3, 5'b00000};
      7'd84: lp = {3'd1, 5'b10000};
      7'd85: lp = {3'd3, 5'b00100};
      7'd86: lp = {3'd4, 5'b00010};
      7'd87: lp = {3'd3, 5'b01100};
      7'd88: lp = {3'd4, 5'b10010};
      7'd89: lp = {3'd4, 5'b10110};
      7'd90: lp = {3'd4, 5'b11000};
      7'd48: lp = {3'd5, 5'b11111};
      7'd49: lp = {3'd5, 5'b01111};
      7'd50: lp = {3'd5, 5'b00111};
      7'd51: lp = {3'd5, 5'b00011};
      7'd52: lp = {3'd5, 5'b00001};
      7'd53: lp = {3'd5, 5'b00000};
      7'd54: lp = {3'd5, 5'b10000};
      7'd55: lp = {3'd5, 5'b11000};
      7'd56: lp = {3'd5, 5'b11100};
      7'd57: lp = {3'd5, 5'b11110};
      default: lp = 8'h00;
    endcase
    r.ok    = (lp[7:5] != 3'd0);
    r.space = (c == 7'd32);
    r.len   = lp[7:5];
    r.pat   = lp[4:0];
    return r;
  endfunction

  state_t        state;
  logic [TW-1:0] tmr;
  logic [2:0]    len_rem;
  logic [4:0]    pat_sh;
  logic          y_p0, busy_p0, err_p0, done_p0;

  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] count, count_ap, count_nx;
  logic          full_p0, empty_p0;
  logic          pop, push, nx_bad;
  logic [6:0]    head, head_nx;
  code_t         cur, nxt;

  // head_nx is the character at the head after this edge, so Err can be
  // registered on entry to LOAD and line up with the LOAD cycle itself.
  always_comb begin
    pop       = (state == LOAD);
    push      = bus.Wr && (!full_p0 || pop);
    count_ap  = count - CW'(pop);
    count_nx  = count_ap + CW'(push);
    rd_ptr_nx = rd_ptr + AW'(pop);
    head      = mem[rd_ptr];
    head_nx   = (count_ap == '0) ? bus.RxData : mem[rd_ptr_nx];
    cur       = morse_rom(head);
    nxt       = morse_rom(head_nx);
    nx_bad    = !nxt.ok && !nxt.space;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.RxData;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full_p0  <= 1'b0;
      empty_p0 <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr   <= rd_ptr_nx;
      count    <= count_nx;
      full_p0  <= (count_nx == CW'(FIFO_DEPTH));
      empty_p0 <= (count_nx == '0);
    end
  end

  // Gaps hand over to LOAD one cycle early when more characters are queued,
  // so the LOAD cycle counts as the final cycle of the gap.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      tmr     <= '0;
      len_rem <= 3'd0;
      pat_sh  <= 5'd0;
      y_p0    <= 1'b0;
      busy_p0 <= 1'b0;
      err_p0  <= 1'b0;
      done_p0 <= 1'b0;
    end else begin
      err_p0  <= 1'b0;
      done_p0 <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start && !empty_p0) begin
            state   <= LOAD;
            busy_p0 <= 1'b1;
            err_p0  <= nx_bad;
          end
        end
        LOAD: begin
          if (cur.space) begin
            state <= WDGAP;
            tmr   <= T_WD;
          end else if (cur.ok) begin
            state   <= MARK;
            y_p0    <= 1'b1;
            tmr     <= cur.pat[4] ? T_DASH : T_DOT;
            pat_sh  <= {cur.pat[3:0], 1'b0};
            len_rem <= cur.len - 3'd1;
          end else if (count_nx != '0) begin
            state  <= LOAD;
            err_p0 <= nx_bad;
          end else begin
            state   <= FIN;
            done_p0 <= 1'b1;
          end
        end
        MARK: begin
          if (tmr != '0) begin
            tmr <= tmr - T_ONE;
          end else if (len_rem != 3'd0) begin
            state <= ELGAP;
            y_p0  <= 1'b0;
            tmr   <= T_DOT;
          end else begin
            state <= CHGAP;
            y_p0  <= 1'b0;
            tmr   <= T_CH;
          end
        end
        ELGAP: begin
          if (tmr != '0) begin
            tmr <= tmr - T_ONE;
          end else begin
            state   <= MARK;
            y_p0    <= 1'b1;
            tmr     <= pat_sh[4] ? T_DASH : T_DOT;
            pat_sh  <= {pat_sh[3:0], 1'b0};
            len_rem <= len_rem - 3'd1;
          end
        end
        CHGAP, WDGAP: begin
          if ((tmr == T_ONE || tmr == '0) && count_nx != '0) begin
            state  <= LOAD;
            err_p0 <= nx_bad;
          end else if (tmr == '0) begin
            state   <= FIN;
            done_p0 <= 1'b1;
          end else begin
            tmr <= tmr - T_ONE;
          end
        end
        FIN: begin
          state   <= IDLE;
          busy_p0 <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busy_p0 <= 1'b0;
          y_p0    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Full  = full_p0;
  assign bus.Empty = empty_p0;
  assign bus.Busy  = busy_p0;
  assign bus.Err   = err_p0;
  assign bus.Done  = done_p0;
  assign bus.Y     = y_p0;

endmodule

// File: tb/tb_morse_tx_fifo.sv
// Directed bench for morse_tx_fifo with UNIT_CYCLES=4, FIFO_DEPTH=8.
// Y is recorded as run lengths (positive = mark, negative = space) per transmission.
module tb_morse_tx_fifo;
  logic clk;
  logic rst;
  morse_tx_fifo_if bus();

  morse_tx_fifo #(.UNIT_CYCLES(4), .FIFO_DEPTH(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  int   runs [0:63];
  int   nruns;
  int   done_at;
  int   errs;
  logic err0;

  task automatic write_ch(input logic [6:0] ch);
    bus.RxData = ch;
    bus.Wr     = 1'b1;
    @(negedge clk);
    bus.Wr     = 1'b0;
  endtask

  task automatic start_pulse();
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  // Called right after start_pulse (cycle 0 = LOAD); optional write/Start at cycle k.
  task automatic capture(input int budget, input int wr_at, input logic [6:0] wr_ch,
                         input int st_at);
    logic y;
    logic prev;
    int   len;
    nruns   = 0;
    done_at = -1;
    errs    = 0;
    len     = 0;
    prev    = 1'b0;
    err0    = bus.Err;
    for (int k = 1; k <= budget; k++) begin
      bus.Wr     = (k == wr_at);
      bus.RxData = wr_ch;
      bus.Start  = (k == st_at);
      @(negedge clk);
      bus.Wr    = 1'b0;
      bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin
        done_at = k;
        break;
      end
      if (bus.Err === 1'b1) errs++;
      y = bus.Y;
      if (len == 0) begin
        prev = y;
        len  = 1;
      end else if (y == prev) begin
        len++;
      end else begin
        if (nruns < 64) runs[nruns] = prev ? len : -len;
        nruns++;
        prev = y;
        len  = 1;
      end
    end
    if (len > 0) begin
      if (nruns < 64) runs[nruns] = prev ? len : -len;
      nruns++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({bus.Y, bus.Busy, bus.Err, bus.Done, bus.Full, bus.Empty} !== 6'b000001) begin
      n_bad++;
      $display("FAIL reset_outputs: Y/Busy/Err/Done/Full/Empty=%b required 000001",
               {bus.Y, bus.Busy, bus.Err, bus.Done, bus.Full, bus.Empty});
    end
    start_pulse();
    @(negedge clk);
    n_vec++;
    if (bus.Busy !== 1'b0 || bus.Y !== 1'b0) begin
      n_bad++;
      $display("FAIL start_empty: Busy=%b Y=%b required 0 0", bus.Busy, bus.Y);
    end
  endtask

  task automatic test_single_e();
    int exp_r [2] = '{4, -12};
    write_ch(7'd69);
    start_pulse();
    capture(100, 0, 7'd0, 0);
    n_vec++;
    if (nruns !== 2) begin
      n_bad++;
      $display("FAIL e_nruns: got %0d required 2", nruns);
    end
    for (int i = 0; i < 2; i++) begin
      n_vec++;
      if (runs[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL e_run%0d: got %0d required %0d", i, runs[i], exp_r[i]);
      end
    end
    n_vec++;
    if (done_at !== 17) begin
      n_bad++;
      $display("FAIL e_done: at cycle %0d required 17", done_at);
    end
    @(negedge clk);
    n_vec++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_bad++;
      $display("FAIL e_idle: Busy=%b Done=%b required 0 0", bus.Busy, bus.Done);
    end
  endtask

  task automatic test_letter_a(input logic [6:0] ch);
    int exp_r [4] = '{4, -4, 12, -12};
    write_ch(ch);
    start_pulse();
    capture(100, 0, 7'd0, 0);
    n_vec++;
    if (nruns !== 4 || done_at !== 33) begin
      n_bad++;
      $display("FAIL a_shape ch=%0d: nruns=%0d done=%0d required 4 33", ch, nruns, done_at);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (runs[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL a_run%0d ch=%0d: got %0d required %0d", i, ch, runs[i], exp_r[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_word_gap();
    int exp_r [4] = '{4, -28, 4, -12};
    write_ch(7'd69);
    write_ch(7'd32);
    write_ch(7'd69);
    start_pulse();
    capture(200, 0, 7'd0, 10);
    n_vec++;
    if (nruns !== 4 || done_at !== 49) begin
      n_bad++;
      $display("FAIL word_shape: nruns=%0d done=%0d required 4 49", nruns, done_at);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (runs[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL word_run%0d: got %0d required %0d", i, runs[i], exp_r[i]);
      end
    end
    n_vec++;
    if (errs !== 0 || err0 !== 1'b0) begin
      n_bad++;
      $display("FAIL word_err: pulses=%0d first=%b required 0 0", errs, err0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int exp_r [4] = '{4, -12, 12, -12};
    write_ch(7'd69);
    start_pulse();
    capture(200, 2, 7'd84, 0);
    n_vec++;
    if (nruns !== 4 || done_at !== 41) begin
      n_bad++;
      $display("FAIL b2b_shape: nruns=%0d done=%0d required 4 41", nruns, done_at);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (runs[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL b2b_run%0d: got %0d required %0d", i, runs[i], exp_r[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 8; i++) begin
      write_ch(7'd69);
      if (i == 6) begin
        n_vec++;
        if (bus.Full !== 1'b0) begin
          n_bad++;
          $display("FAIL full_at7: Full=%b required 0", bus.Full);
        end
      end
    end
    n_vec++;
    if (bus.Full !== 1'b1 || bus.Empty !== 1'b0) begin
      n_bad++;
      $display("FAIL full_at8: Full=%b Empty=%b required 1 0", bus.Full, bus.Empty);
    end
    write_ch(7'd84);
    n_vec++;
    if (bus.Full !== 1'b1) begin
      n_bad++;
      $display("FAIL full_drop: Full=%b required 1", bus.Full);
    end
    start_pulse();
    capture(300, 0, 7'd0, 0);
    n_vec++;
    if (nruns !== 16 || done_at !== 129) begin
      n_bad++;
      $display("FAIL full_shape: nruns=%0d done=%0d required 16 129", nruns, done_at);
    end
    for (int i = 0; i < 16; i++) begin
      n_vec++;
      if (runs[i] !== ((i % 2 == 0) ? 4 : -12)) begin
        n_bad++;
        $display("FAIL full_run%0d: got %0d required %0d", i, runs[i],
                 (i % 2 == 0) ? 4 : -12);
      end
    end
    @(negedge clk);
    n_vec++;
    if (bus.Empty !== 1'b1) begin
      n_bad++;
      $display("FAIL full_drained: Empty=%b required 1", bus.Empty);
    end
  endtask

  task automatic test_unsupported();
    int exp_r [3] = '{-1, 12, -12};
    write_ch(7'd35);
    write_ch(7'd84);
    start_pulse();
    capture(100, 0, 7'd0, 0);
    n_vec++;
    if (err0 !== 1'b1 || errs !== 0) begin
      n_bad++;
      $display("FAIL unsup_err: first=%b later_pulses=%0d required 1 0", err0, errs);
    end
    n_vec++;
    if (nruns !== 3 || done_at !== 26) begin
      n_bad++;
      $display("FAIL unsup_shape: nruns=%0d done=%0d required 3 26", nruns, done_at);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (runs[i] !== exp_r[i]) begin
        n_bad++;
        $display("FAIL unsup_run%0d: got %0d required %0d", i, runs[i], exp_r[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    int busys;
    write_ch(7'd83);
    write_ch(7'd79);
    write_ch(7'd83);
    start_pulse();
    repeat (53) @(negedge clk);
    n_vec++;
    if (bus.Y !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_dash: Y=%b required 1 in second O dash", bus.Y);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({bus.Y, bus.Busy, bus.Empty, bus.Done, bus.Full, bus.Err} !== 6'b001000) begin
      n_bad++;
      $display("FAIL mid_reset: Y/Busy/Empty/Done/Full/Err=%b required 001000",
               {bus.Y, bus.Busy, bus.Empty, bus.Done, bus.Full, bus.Err});
    end
    dones = 0;
    busys = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 10) bus.Start = 1'b1;
      @(negedge clk);
      bus.Start = 1'b0;
      if (bus.Done === 1'b1) dones++;
      if (bus.Busy !== 1'b0 || bus.Y !== 1'b0) busys++;
    end
    n_vec++;
    if (dones !== 0 || busys !== 0) begin
      n_bad++;
      $display("FAIL mid_after: done_pulses=%0d busy_or_y_cycles=%0d required 0 0",
               dones, busys);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.RxData = 7'd0;
    bus.Wr    = 1'b0;
    bus.Start = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_e();
    test_letter_a(7'd65);
    test_letter_a(7'd97);
    test_word_gap();
    test_back_to_back();
    test_fifo_full();
    test_unsupported();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
